multi_watchdog: RTL and testbench

- Parametrised, multi-channel successor to the single-channel watchdog timer.
- Each of NUM_CH channels has its own enable, heartbeat, pre-timeout warning and latched trip. An optional minimum window makes a heartbeat that arrives too early a fault.
- Any trip, or an external force request, produces one stretched force_reset pulse and captures a first-fault record.
- Sits between per-subsystem heartbeat sources and the system reset controller.

---
 rtl/multi_watchdog.sv | 213 +++++++++++++++++++++
 tb/tb_multi_watchdog.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_watchdog.sv
// Multi-channel watchdog: per-channel heartbeat timeout with warning, optional early-kick window,
// one stretched force_reset pulse per idle period, a first-fault record and a saturating trip counter.
module multi_watchdog #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 16,
    parameter int WARN_CYC    = 12,
    parameter int WIN_MIN     = 0,
    parameter int RST_PULSE   = 4,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] enable,
    input  logic [NUM_CH-1:0] heartbeat,
    input  logic              clear,
    input  logic              force_req,
    output logic [NUM_CH-1:0] warning,
    output logic [NUM_CH-1:0] triggered,
    output logic              force_reset,
    output logic              fault_valid,
    output logic [CH_W-1:0]   fault_ch,
    output logic [1:0]        fault_cause,
    output logic [7:0]        trip_count
);

    localparam logic [CNT_W-1:0] L_TO     = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] L_TO_M1  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] L_WARN   = CNT_W'(WARN_CYC);
    localparam int               PW       = (RST_PULSE > 1) ? $clog2(RST_PULSE + 1) : 1;
    localparam logic [PW-1:0]    L_PULSE  = PW'(RST_PULSE);
    localparam int               ADD_W    = $clog2(NUM_CH + 2);

    typedef enum logic {
        PS_IDLE   = 1'b0,
        PS_ACTIVE = 1'b1
    } pulse_state_t;

    logic [NUM_CH-1:0] w_trip_early;
    logic [NUM_CH-1:0] w_trip_tout;
    logic [NUM_CH-1:0] w_trip;
    logic [NUM_CH-1:0] w_warn;
    logic [NUM_CH-1:0] w_trig;
    logic              w_force_evt;
    logic              w_event;

    // Per-channel counter, warning and latched trip.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic             r_warn;
        logic             r_trig;
        logic [CNT_W-1:0] w_cnt_inc;
        logic             w_early_zone;
        logic             w_live;

        if (WIN_MIN > 0) begin : g_win
            assign w_early_zone = (r_cnt < CNT_W'(WIN_MIN));
        end else begin : g_nowin
            assign w_early_zone = 1'b0;
        end

        assign w_cnt_inc       = r_cnt + CNT_W'(1);
        assign w_live          = !clear && enable[g] && !r_trig;
        assign w_trip_early[g] = w_live && heartbeat[g] && w_early_zone;
        assign w_trip_tout[g]  = w_live && !heartbeat[g] && (r_cnt == L_TO_M1);
        assign w_warn[g]       = r_warn;
        assign w_trig[g]       = r_trig;

        always_ff @(posedge clk) begin
            if (!rstn) begin
                r_cnt  <= '0;
                r_warn <= 1'b0;
                r_trig <= 1'b0;
            end else if (clear) begin
                r_cnt  <= '0;
                r_warn <= 1'b0;
                r_trig <= 1'b0;
            end else if (!enable[g]) begin
                r_cnt  <= '0;
                r_warn <= 1'b0;
            end else if (r_trig) begin
                r_cnt  <= r_cnt;
            end else if (heartbeat[g] && w_early_zone) begin
                r_trig <= 1'b1;
                r_warn <= 1'b0;
            end else if (heartbeat[g]) begin
                r_cnt  <= '0;
                r_warn <= 1'b0;
            end else if (r_cnt == L_TO_M1) begin
                r_trig <= 1'b1;
                r_cnt  <= L_TO;
                r_warn <= 1'b0;
            end else begin
                r_cnt  <= w_cnt_inc;
                r_warn <= (w_cnt_inc >= L_WARN);
            end
        end
    end

    assign warning     = w_warn;
    assign triggered   = w_trig;
    assign w_trip      = w_trip_early | w_trip_tout;
    assign w_force_evt = force_req && !clear;
    assign w_event     = (|w_trip) || w_force_evt;

    // Lowest-index tripping channel wins; with no channel trip the cause is the force request.
    logic [CH_W-1:0] w_ff_ch;
    logic [1:0]      w_ff_cause;

    always_comb begin
        w_ff_ch    = '0;
        w_ff_cause = 2'b11;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_trip[i]) begin
                w_ff_ch    = CH_W'(i);
                w_ff_cause = w_trip_early[i] ? 2'b10 : 2'b01;
            end
        end
    end

    logic [ADD_W-1:0] w_trip_add;
    logic [31:0]      w_tc_sum;
    logic [7:0]       w_tc_next;
    logic [7:0]       r_trip_count;

    always_comb begin
        w_trip_add = ADD_W'(w_force_evt);
        for (int i = 0; i < NUM_CH; i++) begin
            w_trip_add = w_trip_add + ADD_W'(w_trip[i]);
        end
        w_tc_sum  = 32'(r_trip_count) + 32'(w_trip_add);
        w_tc_next = (w_tc_sum > 32'd255) ? 8'hFF : w_tc_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_trip_count <= 8'd0;
        end else begin
            r_trip_count <= w_tc_next;
        end
    end

    assign trip_count = r_trip_count;

    logic            r_fault_valid;
    logic [CH_W-1:0] r_fault_ch;
    logic [1:0]      r_fault_cause;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_fault_valid <= 1'b0;
            r_fault_ch    <= '0;
            r_fault_cause <= 2'b00;
        end else if (clear) begin
            r_fault_valid <= 1'b0;
        end else if (!r_fault_valid && w_event) begin
            r_fault_valid <= 1'b1;
            r_fault_ch    <= w_ff_ch;
            r_fault_cause <= w_ff_cause;
        end
    end

    assign fault_valid = r_fault_valid;
    assign fault_ch    = r_fault_ch;
    assign fault_cause = r_fault_cause;

    // Pulse stretcher: events while ACTIVE are ignored, so a pulse is never extended or restarted.
    pulse_state_t  r_pstate;
    pulse_state_t  w_pstate_nxt;
    logic [PW-1:0] r_pcnt;
    logic [PW-1:0] w_pcnt_nxt;
    logic          r_force;

    always_comb begin
        w_pstate_nxt = r_pstate;
        w_pcnt_nxt   = r_pcnt;
        case (r_pstate)
            PS_IDLE: begin
                if (w_event) begin
                    w_pstate_nxt = PS_ACTIVE;
                    w_pcnt_nxt   = PW'(1);
                end
            end
            PS_ACTIVE: begin
                if (r_pcnt == L_PULSE) begin
                    w_pstate_nxt = PS_IDLE;
                    w_pcnt_nxt   = '0;
                end else begin
                    w_pcnt_nxt   = r_pcnt + PW'(1);
                end
            end
            default: begin
                w_pstate_nxt = PS_IDLE;
                w_pcnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pstate <= PS_IDLE;
            r_pcnt   <= '0;
            r_force  <= 1'b0;
        end else begin
            r_pstate <= w_pstate_nxt;
            r_pcnt   <= w_pcnt_nxt;
            r_force  <= (w_pstate_nxt == PS_ACTIVE);
        end
    end

    assign force_reset = r_force;

endmodule

// File: tb/tb_multi_watchdog.sv
// Bench for multi_watchdog: a default instance and a WIN_MIN=4 instance share all inputs.
module tb_multi_watchdog;

    typedef logic [21:0] obs_t;

    typedef struct {
        logic       rstn;
        logic [3:0] en;
        logic [3:0] hb;
        logic       clr;
        logic       frc;
        int         n;
        obs_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] enable;
    logic [3:0] heartbeat;
    logic       clear;
    logic       force_req;

    logic [3:0] warn_d, trig_d, warn_w, trig_w;
    logic       frst_d, fv_d, frst_w, fv_w;
    logic [1:0] ch_d, cs_d, ch_w, cs_w;
    logic [7:0] tc_d, tc_w;
    obs_t       obs_d, obs_w;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    multi_watchdog u_dut (
        .clk(clk), .rstn(rstn), .enable(enable), .heartbeat(heartbeat),
        .clear(clear), .force_req(force_req),
        .warning(warn_d), .triggered(trig_d), .force_reset(frst_d),
        .fault_valid(fv_d), .fault_ch(ch_d), .fault_cause(cs_d), .trip_count(tc_d)
    );

    multi_watchdog #(.WIN_MIN(4)) u_win (
        .clk(clk), .rstn(rstn), .enable(enable), .heartbeat(heartbeat),
        .clear(clear), .force_req(force_req),
        .warning(warn_w), .triggered(trig_w), .force_reset(frst_w),
        .fault_valid(fv_w), .fault_ch(ch_w), .fault_cause(cs_w), .trip_count(tc_w)
    );

    assign obs_d = {warn_d, trig_d, frst_d, fv_d, ch_d, cs_d, tc_d};
    assign obs_w = {warn_w, trig_w, frst_w, fv_w, ch_w, cs_w, tc_w};

    function automatic obs_t pk(input logic [3:0] wr, input logic [3:0] tr, input logic fr,
                                input logic fv, input logic [1:0] ch, input logic [1:0] cs,
                                input logic [7:0] tc);
        return {wr, tr, fr, fv, ch, cs, tc};
    endfunction

    // fault_ch/fault_cause are only meaningful while fault_valid is expected high.
    task automatic check(input string name, input obs_t got, input obs_t exp);
        obs_t mask;
        mask = '1;
        if (!exp[12]) mask[11:8] = 4'h0;
        n_total++;
        if ((got & mask) === (exp & mask)) n_pass++;
        else $display("FAIL %s: got %h expected %h (warn,trig,frst,fv,ch,cause,tc)",
                      name, got & mask, exp & mask);
    endtask

    task automatic both(input string name, input obs_t exp_d, input obs_t exp_w);
        check({name, "/dflt"}, obs_d, exp_d);
        check({name, "/win"}, obs_w, exp_w);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    vec_t tbl[12];

    initial begin
        rstn = 1'b0; enable = 4'h0; heartbeat = 4'h0; clear = 1'b0; force_req = 1'b0;

        tbl[0]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 2,  pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd0)};
        tbl[1]  = '{1'b1, 4'h1, 4'h0, 1'b0, 1'b0, 11, pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd0)};
        tbl[2]  = '{1'b1, 4'h1, 4'h0, 1'b0, 1'b0, 1,  pk(4'h1, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd0)};
        tbl[3]  = '{1'b1, 4'h1, 4'h0, 1'b0, 1'b0, 3,  pk(4'h1, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd0)};
        tbl[4]  = '{1'b1, 4'h1, 4'h0, 1'b0, 1'b0, 1,  pk(4'h0, 4'h1, 1'b1, 1'b1, 2'd0, 2'b01, 8'd1)};
        tbl[5]  = '{1'b1, 4'h1, 4'h0, 1'b0, 1'b0, 3,  pk(4'h0, 4'h1, 1'b1, 1'b1, 2'd0, 2'b01, 8'd1)};
        tbl[6]  = '{1'b1, 4'h1, 4'h0, 1'b0, 1'b0, 1,  pk(4'h0, 4'h1, 1'b0, 1'b1, 2'd0, 2'b01, 8'd1)};
        tbl[7]  = '{1'b1, 4'h1, 4'h0, 1'b1, 1'b0, 1,  pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd1)};
        tbl[8]  = '{1'b1, 4'h1, 4'h0, 1'b0, 1'b0, 15, pk(4'h1, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd1)};
        tbl[9]  = '{1'b1, 4'h1, 4'h0, 1'b0, 1'b0, 1,  pk(4'h0, 4'h1, 1'b1, 1'b1, 2'd0, 2'b01, 8'd2)};
        tbl[10] = '{1'b1, 4'h1, 4'h0, 1'b0, 1'b0, 4,  pk(4'h0, 4'h1, 1'b0, 1'b1, 2'd0, 2'b01, 8'd2)};
        tbl[11] = '{1'b1, 4'h1, 4'h0, 1'b1, 1'b0, 1,  pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd2)};

        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            rstn = tbl[i].rstn; enable = tbl[i].en; heartbeat = tbl[i].hb;
            clear = tbl[i].clr; force_req = tbl[i].frc;
            tick(tbl[i].n);
            both($sformatf("vec%0d", i), tbl[i].exp, tbl[i].exp);
        end
        clear = 1'b0;

        // Heartbeat every 10 cycles keeps the counter below the warning level.
        for (int p = 0; p < 20; p++) begin
            heartbeat = 4'h0; tick(9);
            both("hb10_pre", pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd2),
                             pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd2));
            heartbeat = 4'h1; tick(1);
            both("hb10_kick", pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd2),
                              pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd2));
        end

        // Heartbeat every 13 cycles: one warning cycle before each kick.
        for (int p = 0; p < 5; p++) begin
            heartbeat = 4'h0; tick(11);
            both("hb13_c11", pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd2),
                             pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd2));
            tick(1);
            both("hb13_warn", pk(4'h1, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd2),
                              pk(4'h1, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd2));
            heartbeat = 4'h1; tick(1);
            both("hb13_kick", pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd2),
                              pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd2));
        end
        heartbeat = 4'h0;

        // Early heartbeat on ch2: only the windowed instance trips.
        clear = 1'b1; enable = 4'b0101; tick(1);
        clear = 1'b0; tick(5);
        heartbeat = 4'b0100; tick(1);
        both("win_ok_kick", pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd2),
                            pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd2));
        heartbeat = 4'h0; tick(2);
        heartbeat = 4'b0100; tick(1);
        heartbeat = 4'h0;
        both("win_early", pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd2),
                          pk(4'h0, 4'b0100, 1'b1, 1'b1, 2'd2, 2'b10, 8'd3));
        tick(6);
        both("win_ch0_warn", pk(4'h1, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd2),
                             pk(4'h1, 4'b0100, 1'b0, 1'b1, 2'd2, 2'b10, 8'd3));
        tick(1);
        both("win_ch0_trip", pk(4'h0, 4'h1, 1'b1, 1'b1, 2'd0, 2'b01, 8'd3),
                             pk(4'h0, 4'b0101, 1'b1, 1'b1, 2'd2, 2'b10, 8'd4));
        tick(4);
        both("win_pulse_end", pk(4'h0, 4'h1, 1'b0, 1'b1, 2'd0, 2'b01, 8'd3),
                              pk(4'h0, 4'b0101, 1'b0, 1'b1, 2'd2, 2'b10, 8'd4));

        // Channels 1 and 3 trip together; force_req mid-pulse.
        clear = 1'b1; enable = 4'b1010; tick(1);
        both("pair_clr", pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd3),
                         pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd4));
        clear = 1'b0; tick(15);
        both("pair_warn", pk(4'b1010, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd3),
                          pk(4'b1010, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd4));
        tick(1);
        both("pair_trip", pk(4'h0, 4'b1010, 1'b1, 1'b1, 2'd1, 2'b01, 8'd5),
                          pk(4'h0, 4'b1010, 1'b1, 1'b1, 2'd1, 2'b01, 8'd6));
        force_req = 1'b1; tick(1);
        force_req = 1'b0;
        both("pair_frc", pk(4'h0, 4'b1010, 1'b1, 1'b1, 2'd1, 2'b01, 8'd6),
                         pk(4'h0, 4'b1010, 1'b1, 1'b1, 2'd1, 2'b01, 8'd7));
        tick(2);
        both("pair_last_hi", pk(4'h0, 4'b1010, 1'b1, 1'b1, 2'd1, 2'b01, 8'd6),
                             pk(4'h0, 4'b1010, 1'b1, 1'b1, 2'd1, 2'b01, 8'd7));
        tick(1);
        both("pair_not_ext", pk(4'h0, 4'b1010, 1'b0, 1'b1, 2'd1, 2'b01, 8'd6),
                             pk(4'h0, 4'b1010, 1'b0, 1'b1, 2'd1, 2'b01, 8'd7));

        // force_req alone, then clear together with force_req.
        clear = 1'b1; enable = 4'h0; tick(1);
        clear = 1'b0; force_req = 1'b1; tick(1);
        force_req = 1'b0;
        both("frc_alone", pk(4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 2'b11, 8'd7),
                          pk(4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 2'b11, 8'd8));
        tick(4);
        both("frc_end", pk(4'h0, 4'h0, 1'b0, 1'b1, 2'd0, 2'b11, 8'd7),
                        pk(4'h0, 4'h0, 1'b0, 1'b1, 2'd0, 2'b11, 8'd8));
        clear = 1'b1; force_req = 1'b1; tick(1);
        both("clr_beats_frc", pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd7),
                              pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd8));
        clear = 1'b0; force_req = 1'b0; tick(1);
        both("clr_no_pulse", pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd7),
                             pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd8));

        // Disable at counter 10 restarts the count.
        enable = 4'h1; tick(10);
        both("dis_c10", pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd7),
                        pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd8));
        enable = 4'h0; tick(1);
        enable = 4'h1; tick(11);
        both("reen_c11", pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd7),
                         pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd8));
        tick(1);
        both("reen_warn", pk(4'h1, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd7),
                          pk(4'h1, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd8));
        tick(4);
        both("reen_trip", pk(4'h0, 4'h1, 1'b1, 1'b1, 2'd0, 2'b01, 8'd8),
                          pk(4'h0, 4'h1, 1'b1, 1'b1, 2'd0, 2'b01, 8'd9));
        tick(1);
        both("mid_pulse", pk(4'h0, 4'h1, 1'b1, 1'b1, 2'd0, 2'b01, 8'd8),
                          pk(4'h0, 4'h1, 1'b1, 1'b1, 2'd0, 2'b01, 8'd9));

        // Reset mid-pulse aborts it and zeroes everything.
        rstn = 1'b0; enable = 4'h0; tick(1);
        both("rst_mid_pulse", pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd0),
                              pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd0));
        rstn = 1'b1; tick(1);
        both("post_rst", pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd0),
                         pk(4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'b00, 8'd0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
